// File: rtl/rns_pkg.sv
// Shared definitions for the RNS residue select pipeline.
//   RNS_WIDTH / RNS_CHANNELS : default residue width and channel count
//   rns_vec_t                : one full beat of residues at the defaults
//   rns_state_e              : skid-buffer occupancy states
//   popcount()               : number of set bits in a select vector
package rns_pkg;

    localparam int RNS_WIDTH    = 7;
    localparam int RNS_CHANNELS = 3;

    typedef logic [RNS_CHANNELS*RNS_WIDTH-1:0] rns_vec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } rns_state_e;

    // Select vectors are zero-extended to 32 bits by the caller, so this
    // covers any channel count up to 32.
    function automatic int unsigned popcount(input logic [31:0] sel);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(sel[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rns_sel_lane.sv
// Per-channel 2:1 residue select. Pure bit select, no arithmetic.
//   num_i  : raw residue
//   comp_i : complement / corrected residue
//   sel_i  : 1 picks comp_i, 0 picks num_i
//   res_o  : selected residue
module rns_sel_lane #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] num_i,
    input  logic [WIDTH-1:0] comp_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = sel_i ? comp_i : num_i;

endmodule

// File: rtl/rns_residue_select_pipe.sv
// Multi-channel residue/complement selector with a valid/ready skid buffer
// and a saturating count of complement selections.
//   clk, rst_n           : clock, async active-low reset
//   in_num, in_comp      : per-channel residues, channel k at [k*WIDTH +: WIDTH]
//   in_sel               : per-channel select (1 = complement)
//   in_valid / in_ready  : upstream handshake (in_ready is a flop)
//   out_result, out_sel  : selected beat and its select bits
//   out_valid / out_ready: downstream handshake
//   sel_count, clr_count : saturating complement-select count and its clear
module rns_residue_select_pipe
    import rns_pkg::*;
#(
    parameter int WIDTH    = RNS_WIDTH,
    parameter int CHANNELS = RNS_CHANNELS,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_num,
    input  logic [CHANNELS*WIDTH-1:0] in_comp,
    input  logic [CHANNELS-1:0]       in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_result,
    output logic [CHANNELS-1:0]       out_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          sel_count,
    input  logic                      clr_count
);

    localparam int              DW      = CHANNELS*WIDTH;
    localparam int              SW      = CNT_W + 33;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Combinational select, one lane per channel
    logic [DW-1:0] sel_res;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        rns_sel_lane #(.WIDTH(WIDTH)) u_lane (
            .num_i  (in_num[k*WIDTH +: WIDTH]),
            .comp_i (in_comp[k*WIDTH +: WIDTH]),
            .sel_i  (in_sel[k]),
            .res_o  (sel_res[k*WIDTH +: WIDTH])
        );
    end

    // Skid buffer state
    rns_state_e          state_q, state_d;
    logic [DW-1:0]       main_res_q, main_res_d;
    logic [CHANNELS-1:0] main_sel_q, main_sel_d;
    logic [DW-1:0]       skid_res_q, skid_res_d;
    logic [CHANNELS-1:0] skid_sel_q, skid_sel_d;
    logic                in_ready_q, out_valid_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic accept, xfer;
    assign accept = in_valid & in_ready_q;
    assign xfer   = out_valid_q & out_ready;

    always_comb begin
        state_d    = state_q;
        main_res_d = main_res_q;
        main_sel_d = main_sel_q;
        skid_res_d = skid_res_q;
        skid_sel_d = skid_sel_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_res_d = sel_res;
                    main_sel_d = in_sel;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    main_res_d = sel_res;
                    main_sel_d = in_sel;
                end else if (accept) begin
                    // Downstream stalled: park the new beat behind main
                    skid_res_d = sel_res;
                    skid_sel_d = in_sel;
                    state_d    = ST_FULL;
                end else if (xfer) begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so accept cannot occur
                if (xfer) begin
                    main_res_d = skid_res_q;
                    main_sel_d = skid_sel_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Saturating counter; the sum is computed wide enough to never overflow
    logic [SW-1:0] cnt_sum;
    assign cnt_sum = SW'(cnt_q) + SW'(popcount(32'(in_sel)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_res_q  <= '0;
            main_sel_q  <= '0;
            skid_res_q  <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_res_q  <= main_res_d;
            main_sel_q  <= main_sel_d;
            skid_res_q  <= skid_res_d;
            skid_sel_q  <= skid_sel_d;
            // Handshake outputs are flops decoded from the next state
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = main_res_q;
    assign out_sel    = main_sel_q;
    assign sel_count  = cnt_q;

endmodule

// File: tb/tb_rns_residue_select_pipe.sv
module tb_rns_residue_select_pipe;
    import rns_pkg::*;

    localparam int W  = 7;
    localparam int C  = 3;
    localparam int DW = W*C;

    logic          clk, rst_n;
    logic [DW-1:0] in_num, in_comp;
    logic [C-1:0]  in_sel;
    logic          in_valid, out_ready, clr_count;

    logic          in_ready, out_valid, in_ready4, out_valid4;
    logic [DW-1:0] out_result, out_result4;
    logic [C-1:0]  out_sel, out_sel4;
    logic [15:0]   sel_count;
    logic [3:0]    sel_count4;

    int n_vec, n_err;

    rns_residue_select_pipe #(.WIDTH(W), .CHANNELS(C), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_num(in_num), .in_comp(in_comp),
        .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_result(out_result), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .sel_count(sel_count), .clr_count(clr_count)
    );

    // Same stimulus, narrow counter for the saturation checks
    rns_residue_select_pipe #(.WIDTH(W), .CHANNELS(C), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_num(in_num), .in_comp(in_comp),
        .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready4),
        .out_result(out_result4), .out_sel(out_sel4), .out_valid(out_valid4),
        .out_ready(out_ready), .sel_count(sel_count4), .clr_count(clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] n, input logic [DW-1:0] c,
                         input logic [C-1:0] s, input logic v);
        in_num = n; in_comp = c; in_sel = s; in_valid = v;
    endtask

    function automatic logic [DW-1:0] ref_sel(input logic [DW-1:0] n,
                                               input logic [DW-1:0] c,
                                               input logic [C-1:0] s);
        logic [DW-1:0] r;
        for (int k = 0; k < C; k++) begin
            for (int b = 0; b < W; b++) begin
                r[k*W+b] = s[k] ? c[k*W+b] : n[k*W+b];
            end
        end
        return r;
    endfunction

    logic [DW-1:0] a_n, a_c, b_n, b_c, c_n, c_c, rn, rc;
    logic [C-1:0]  rs;
    int            ones;

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
        drive('0, '0, '0, 1'b0);

        // ---- reset / idle
        repeat (3) step();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("idle_out_valid", 64'(out_valid), 64'(0));
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        chk("idle_sel_count", 64'(sel_count), 64'(0));
        chk("idle_out_result", 64'(out_result), 64'(0));
        chk("idle_out_sel", 64'(out_sel), 64'(0));

        // ---- basic select
        out_ready = 1'b1;
        drive({7'h05, 7'h12, 7'h7F}, {7'h02, 7'h0C, 7'h00}, 3'b101, 1'b1);
        step();
        drive('0, '0, '0, 1'b0);
        chk("basic_valid", 64'(out_valid), 64'(1));
        chk("basic_result", 64'(out_result), 64'({7'h02, 7'h12, 7'h00}));
        chk("basic_sel", 64'(out_sel), 64'(3'b101));
        chk("basic_count", 64'(sel_count), 64'(2));
        step();
        chk("basic_drain", 64'(out_valid), 64'(0));

        // ---- backpressure: A to main, B to skid, C held off
        a_n = {7'h11, 7'h22, 7'h33}; a_c = {7'h44, 7'h55, 7'h66};
        b_n = {7'h01, 7'h02, 7'h03}; b_c = {7'h7A, 7'h7B, 7'h7C};
        c_n = {7'h10, 7'h20, 7'h30}; c_c = {7'h0A, 7'h0B, 7'h0C};
        out_ready = 1'b0;
        drive(a_n, a_c, 3'b001, 1'b1);
        step();
        chk("bp_a_main", 64'(out_result), 64'({7'h11, 7'h22, 7'h66}));
        chk("bp_one_ready", 64'(in_ready), 64'(1));
        drive(b_n, b_c, 3'b010, 1'b1);
        step();
        chk("bp_full_ready", 64'(in_ready), 64'(0));
        chk("bp_a_hold", 64'(out_result), 64'({7'h11, 7'h22, 7'h66}));
        drive(c_n, c_c, 3'b011, 1'b1);
        step();
        chk("bp_c_blocked", 64'(in_ready), 64'(0));
        chk("bp_a_stable", 64'({out_valid, out_sel, out_result}),
            64'({1'b1, 3'b001, 7'h11, 7'h22, 7'h66}));
        out_ready = 1'b1;
        step();
        chk("bp_b_out", 64'({out_valid, out_sel, out_result}),
            64'({1'b1, 3'b010, 7'h01, 7'h7B, 7'h03}));
        step();
        drive('0, '0, '0, 1'b0);
        chk("bp_c_out", 64'({out_valid, out_sel, out_result}),
            64'({1'b1, 3'b011, 7'h10, 7'h0B, 7'h0C}));
        step();
        chk("bp_empty", 64'(out_valid), 64'(0));
        // 2 (basic) + 1 + 1 + 2
        chk("bp_count", 64'(sel_count), 64'(6));
        chk("bp_count4", 64'(sel_count4), 64'(6));

        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        chk("clr_count", 64'(sel_count), 64'(0));

        // ---- streaming: one beat per cycle
        ones = 0;
        for (int i = 0; i < 100; i++) begin
            rn = DW'($urandom); rc = DW'($urandom); rs = C'($urandom);
            for (int k = 0; k < C; k++) ones += int'(rs[k]);
            drive(rn, rc, rs, 1'b1);
            step();
            chk("stream_beat", 64'({out_valid, in_ready, out_sel, out_result}),
                64'({1'b1, 1'b1, rs, ref_sel(rn, rc, rs)}));
        end
        drive('0, '0, '0, 1'b0);
        step();
        chk("stream_count", 64'(sel_count), 64'(ones));
        chk("stream_count4", 64'(sel_count4), 64'((ones > 15) ? 15 : ones));

        // ---- saturation on the 4-bit counter: 3,6,9,12,15,15
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive({7'h01, 7'h02, 7'h03}, {7'h04, 7'h05, 7'h06}, 3'b111, 1'b1);
            step();
            if (i == 4) chk("sat_reach15", 64'(sel_count4), 64'(15));
        end
        chk("sat_hold15", 64'(sel_count4), 64'(15));
        chk("sat_wide18", 64'(sel_count), 64'(18));
        // Clear wins over a simultaneous accept
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        drive('0, '0, '0, 1'b0);
        chk("clr_accept", 64'(sel_count), 64'(0));
        chk("clr_accept4", 64'(sel_count4), 64'(0));
        step();

        // ---- async reset while FULL
        out_ready = 1'b0;
        drive({7'h5A, 7'h5A, 7'h5A}, '0, 3'b000, 1'b1);
        step();
        drive({7'h3C, 7'h3C, 7'h3C}, '0, 3'b000, 1'b1);
        step();
        drive('0, '0, '0, 1'b0);
        chk("full_before_rst", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_result", 64'(out_result), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_ready", 64'(in_ready), 64'(1));
        chk("post_rst_valid", 64'(out_valid), 64'(0));
        step();
        chk("post_rst_novalid", 64'(out_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case something above never returns
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
